clk_burst_gen: RTL and testbench
================================

# clk_burst_gen

- Parametrised clock-divider and pulse-burst generator, derived from our free-running `clock_gen`.
- Divides the system `clock` by a programmable even ratio (2·half_period) to produce `clk_out`.
- Modes: free-run, or burst (a programmed number of output periods, then stop).
- Clean start/stop: `clk_out` never produces a runt high phase.
- Feeds test/stimulus logic and slow peripheral strobes; `clk_out` is used as a data/enable signal, never as a clock.

## Interface
Parameters:
- CNT_W, 16, width of `half_period` and the internal phase counter.
- BURST_W, 8, width of `burst_len` and `period_cnt`.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- enable  in  1  run request (level).
- mode  in  1  0 = free-run, 1 = burst.
- half_period  in  CNT_W  phase length in clock cycles; 0 treated as 1.
- burst_len  in  BURST_W  periods per burst; 0 treated as 1.
- clk_out  out  1  divided output, registered.
- rise_tick  out  1  high for exactly the cycle in which `clk_out` has just risen.
- period_cnt  out  BURST_W  completed periods since last start; wraps.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
States:
- IDLE: `clk_out` = 0.
- RUN: generating periods.
- STOP: finishing the current high phase after `enable` drops.

Sampling:
- H_eff = max(half_period, 1) and N_eff = max(burst_len, 1).
- `mode` and N_eff are captured only on IDLE→RUN.
- H_eff is captured on IDLE→RUN and again at every low→high boundary, so a new value takes effect from the next period.

Start:
- IDLE with enable=1 and no burst lock → RUN.
- On that edge: clk_out←1, rise_tick←1, phase counter←0, period_cnt←0.

Phase counting:
- In RUN, the counter increments each cycle.
- When it reaches H_eff−1 the phase ends and the counter clears. Each phase is exactly H_eff cycles.

End of high phase:
- clk_out←0.
- If enable=0 at that edge → IDLE.

End of low phase (period complete):
- period_cnt+1.
- Free-run, or burst with period_cnt+1 < N_eff: clk_out←1, rise_tick←1.
- Burst with period_cnt+1 == N_eff: go to IDLE, clk_out stays 0, done←1 for one cycle, burst lock set.

Enable dropped in RUN:
- During a low phase: IDLE on the next edge, clk_out stays 0, that period is not counted.
- During a high phase: go to STOP. The high phase completes its full H_eff, clk_out falls, then IDLE. No low phase, no count increment, no done.

Other rules:
- STOP ignores enable re-assertion.
- Burst lock clears when enable is sampled 0. A burst therefore restarts only on a fresh enable assertion; free-run restarts whenever enable is high in IDLE.
- period_cnt wraps modulo 2^BURST_W in free-run and holds its value in IDLE until the next start.

## Timing
- Reset (async, immediate) clears everything to 0:
  - clk_out, rise_tick, done, busy, period_cnt.
  - Phase counter, burst lock, state = IDLE.
- A reset assertion mid-burst aborts the burst with no done pulse.
- Latency: clk_out rises on the first edge at which enable=1 is sampled in IDLE. That edge is called k.
- Waveform: high after edges k…k+H−1, falls at k+H, rises again at k+2H.
- rise_tick and done are registered, each exactly 1 cycle wide.
- busy is high from edge k to the edge returning to IDLE.
- done and the busy=0 transition occur on the same edge.

## Test plan
- Reset: reset_n=0 asynchronously, mid-run → all outputs 0 at once; after release, remain 0 with enable=0.
- Free-run, H=3, enable sampled at edge 0:
  - clk_out=1 after edges 0–2, 0 after edges 3–5, rises at 6, 12.
  - rise_tick at 0, 6, 12; period_cnt=1 after edge 6, 2 after edge 12.
- Burst, H=2, N=3, enable held high:
  - Rises at edges 0, 4, 8; done=1, busy=0, period_cnt=3 after edge 12.
  - No restart while enable stays high; enable low for 1 cycle then high → new burst.
- H=0 and N=0 in burst → treated as 1: clk_out high 1 cycle, low 1 cycle, done after edge 2.
- enable dropped at edge 1 with H=4 (high phase):
  - STOP; clk_out falls at edge 4, IDLE at edge 4.
  - period_cnt=0, no done; re-assertion during STOP ignored.
- Live update: free-run H=2, change half_period to 5 during the first high phase → first period 2+2 cycles, subsequent phases 5 cycles.

Source files
------------

// File: rtl/clk_burst_gen.sv
// rtl/clk_burst_gen.sv - programmable even-ratio clock divider with free-run and burst modes
//
// Divides `clock` by 2*H_eff to produce clk_out, a registered enable-style
// waveform. It is used as data or a strobe, never as a clock. In burst mode a
// programmed number of periods is produced, then the block stops. The block
// never emits a short high phase.
//
// Ports:
//   clock        in   system clock, all state changes on rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   run request (level)
//   mode         in   0 = free-run, 1 = burst (captured at start)
//   half_period  in   phase length in clocks, 0 treated as 1
//   burst_len    in   periods per burst, 0 treated as 1 (captured at start)
//   clk_out      out  divided output
//   rise_tick    out  one-cycle pulse in the cycle clk_out has just risen
//   period_cnt   out  completed periods since last start, wraps
//   busy         out  generator not idle
//   done         out  one-cycle pulse when a burst completes
module clk_burst_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               clk_out,
  output logic               rise_tick,
  output logic [BURST_W-1:0] period_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q;
  logic               clk_out_q;
  logic               rise_q;
  logic               done_q;
  logic               busy_q;
  logic               mode_q;
  // Set when a burst completes; blocks a restart until enable is seen low.
  logic               lock_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   h_q;
  logic [BURST_W-1:0] n_q;
  logic [BURST_W-1:0] pcnt_q;

  logic [CNT_W-1:0]   h_eff_d;
  logic [BURST_W-1:0] n_eff_d;
  logic [BURST_W-1:0] pcnt_inc_d;
  logic               phase_end_d;

  always_comb begin
    h_eff_d     = (half_period == '0) ? CNT_W'(1) : half_period;
    n_eff_d     = (burst_len == '0) ? BURST_W'(1) : burst_len;
    pcnt_inc_d  = pcnt_q + BURST_W'(1);
    phase_end_d = (cnt_q == (h_q - CNT_W'(1)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      h_q       <= '0;
      n_q       <= '0;
      pcnt_q    <= '0;
    end else begin
      rise_q <= 1'b0;
      done_q <= 1'b0;
      if (!enable) begin
        lock_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable && !lock_q) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            clk_out_q <= 1'b1;
            rise_q    <= 1'b1;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            h_q       <= h_eff_d;
            n_q       <= n_eff_d;
            mode_q    <= mode;
          end
        end

        RUN: begin
          if (clk_out_q) begin
            // High phase: a drop of enable lets the phase run to full length.
            if (phase_end_d) begin
              clk_out_q <= 1'b0;
              cnt_q     <= '0;
              if (!enable) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (!enable) begin
                state_q <= STOP;
              end
            end
          end else begin
            // Low phase: a drop of enable abandons the uncounted period.
            if (!enable) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (phase_end_d) begin
              pcnt_q <= pcnt_inc_d;
              cnt_q  <= '0;
              if (mode_q && (pcnt_inc_d == n_q)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                lock_q  <= 1'b1;
              end else begin
                clk_out_q <= 1'b1;
                rise_q    <= 1'b1;
                // A new half_period takes effect from the next period.
                h_q       <= h_eff_d;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        STOP: begin
          // Enable is ignored here; only the phase length matters.
          if (phase_end_d) begin
            clk_out_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out    = clk_out_q;
  assign rise_tick  = rise_q;
  assign period_cnt = pcnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_clk_burst_gen.sv
// tb/tb_clk_burst_gen.sv - directed and randomized bench for clk_burst_gen
module tb_clk_burst_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] half_period = 16'd0;
  logic [7:0]  burst_len = 8'd0;
  logic        clk_out;
  logic        rise_tick;
  logic [7:0]  period_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Reference model: time offset within the current period.
  bit       m_active = 0;
  bit       m_stopping = 0;
  bit       m_burst = 0;
  bit       m_lock = 0;
  bit       m_rise = 0;
  bit       m_done = 0;
  int       m_t = 0;
  int       m_h = 1;
  int       m_n = 1;
  logic [7:0] m_cnt = 8'd0;

  clk_burst_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .half_period(half_period),
    .burst_len(burst_len),
    .clk_out(clk_out),
    .rise_tick(rise_tick),
    .period_cnt(period_cnt),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_stopping = 0; m_lock = 0; m_rise = 0; m_done = 0;
    m_t = 0; m_cnt = 8'd0;
  endtask

  task automatic model_edge(input bit en, input bit md, input int hp, input int bl);
    m_rise = 0;
    m_done = 0;
    if (!m_active) begin
      if (en && !m_lock) begin
        m_active = 1; m_stopping = 0; m_t = 0;
        m_h = (hp == 0) ? 1 : hp;
        m_n = (bl == 0) ? 1 : bl;
        m_burst = md; m_cnt = 8'd0; m_rise = 1;
      end
    end else if (m_stopping) begin
      m_t++;
      if (m_t == m_h) m_active = 0;
    end else if (m_t < m_h) begin
      m_t++;
      if (!en) begin
        if (m_t == m_h) m_active = 0;
        else m_stopping = 1;
      end
    end else begin
      if (!en) m_active = 0;
      else begin
        m_t++;
        if (m_t == 2 * m_h) begin
          m_cnt++;
          if (m_burst && (int'(m_cnt) == m_n)) begin
            m_active = 0; m_done = 1; m_lock = 1;
          end else begin
            m_t = 0; m_h = (hp == 0) ? 1 : hp; m_rise = 1;
          end
        end
      end
    end
    if (!en) m_lock = 0;
  endtask

  task automatic check_model();
    chk("m_clk_out", {31'd0, clk_out}, {31'd0, (m_active && (m_t < m_h))});
    chk("m_rise", {31'd0, rise_tick}, {31'd0, m_rise});
    chk("m_done", {31'd0, done}, {31'd0, m_done});
    chk("m_busy", {31'd0, busy}, {31'd0, m_active});
    chk("m_pcnt", {24'd0, period_cnt}, {24'd0, m_cnt});
  endtask

  task automatic step(input bit en, input bit md, input int hp, input int bl);
    enable = en; mode = md; half_period = hp[15:0]; burst_len = bl[7:0];
    @(posedge clock);
    model_edge(en, md, hp, bl);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {27'd0, clk_out, rise_tick, done, busy, |period_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clock);
    #1 check_all_zero("held_reset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 check_all_zero("reset_state");
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 3, 0);
    check_all_zero("idle_after_reset");

    // Free-run H=3
    for (int i = 0; i <= 12; i++) begin
      step(1, 0, 3, 0);
      chk("fr_clk", {31'd0, clk_out}, {31'd0, ((i % 6) < 3)});
      chk("fr_rise", {31'd0, rise_tick}, {31'd0, ((i % 6) == 0)});
    end
    chk("fr_pcnt12", {24'd0, period_cnt}, 32'd2);
    step(1, 0, 3, 0);
    do_reset();
    step(0, 0, 3, 0);
    check_all_zero("post_reset_idle");

    // Burst H=2 N=3
    for (int i = 0; i <= 12; i++) begin
      step(1, 1, 2, 3);
      chk("b_rise", {31'd0, rise_tick}, {31'd0, (i == 0 || i == 4 || i == 8)});
    end
    chk("b_done", {31'd0, done}, 32'd1);
    chk("b_busy", {31'd0, busy}, 32'd0);
    chk("b_pcnt", {24'd0, period_cnt}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2, 3);
      chk("b_norestart", {31'd0, busy}, 32'd0);
    end
    chk("b_pcnt_hold", {24'd0, period_cnt}, 32'd3);
    step(0, 1, 2, 3);
    step(1, 1, 2, 3);
    chk("b_restart", {30'd0, busy, rise_tick}, 32'd3);
    for (int i = 0; i < 4; i++) step(0, 1, 2, 3);
    chk("b_stopped", {31'd0, busy}, 32'd0);

    // H=0, N=0 burst
    step(1, 1, 0, 0);
    chk("z_hi", {31'd0, clk_out}, 32'd1);
    step(1, 1, 0, 0);
    chk("z_lo", {31'd0, clk_out}, 32'd0);
    step(1, 1, 0, 0);
    chk("z_done", {30'd0, done, busy}, 32'd2);
    step(0, 1, 0, 0);

    // Enable drop in high phase, H=4
    step(1, 1, 4, 5);
    step(0, 1, 4, 5);
    chk("s_busy1", {30'd0, busy, clk_out}, 32'd3);
    for (int i = 2; i <= 3; i++) begin
      step(1, 1, 4, 5);
      chk("s_stop_hi", {30'd0, busy, clk_out}, 32'd3);
    end
    step(1, 1, 4, 5);
    chk("s_end", {29'd0, busy, clk_out, done}, 32'd0);
    chk("s_pcnt", {24'd0, period_cnt}, 32'd0);
    step(0, 1, 4, 5);
    chk("s_idle", {31'd0, busy}, 32'd0);

    // Live half_period update
    step(1, 0, 2, 0);
    for (int i = 1; i <= 14; i++) begin
      step(1, 0, 5, 0);
      if (i == 4 || i == 8 || i == 14) chk("lu_hi", {31'd0, clk_out}, 32'd1);
      if (i == 3 || i == 9 || i == 13) chk("lu_lo", {31'd0, clk_out}, 32'd0);
      chk("lu_rise", {31'd0, rise_tick}, {31'd0, (i == 4 || i == 14)});
    end
    for (int i = 0; i < 8; i++) step(0, 0, 5, 0);

    // Randomized against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
